// File: rtl/bubble_out_buffer.sv
// Ping-pong page buffer between the SPI loader and the bubble data outputs.
// Optional macro BUBBLE_CHSWAP_EN adds nSWAPEN to reverse the channel order per page.
module bubble_out_buffer #(
  parameter int NCH      = 2,
  parameter int PAGE_LEN = 584,
  parameter int CNT_W    = 13,
  localparam int CH_W    = $clog2(NCH)
) (
  input  logic                  MCLK,
  input  logic                  nRESET,
`ifdef BUBBLE_CHSWAP_EN
  input  logic                  nSWAPEN,
`endif
  input  logic [2:0]            ACCTYPE,
  input  logic [CNT_W-1:0]      BOUTCYCLENUM,
  input  logic                  nBOUTCLKEN,
  input  logic                  nOUTBUFWCLKEN,
  input  logic [CNT_W+CH_W-1:0] OUTBUFWADDR,
  input  logic                  OUTBUFWDATA,
  input  logic                  BANKDONE,
  output logic [NCH-1:0]        DOUT,
  output logic                  WREADY,
  output logic                  OVERRUN,
  output logic                  UNDERRUN
);

  localparam int IDX_W = $clog2(2 * PAGE_LEN);

  typedef enum logic [1:0] {IDLE, STREAM, STARVE, DONE} state_t;

  state_t           state_q, state_d;
  logic             wb_q, wb_d, rb_q, rb_d;
  logic [1:0]       full_q, full_d;
  logic [NCH-1:0]   dout_q, dout_d;
  logic             overrun_q, overrun_d;
  logic             underrun_q, underrun_d;
  logic             swap_q, swap_d;
  logic             acc_idle_q;

  logic             swap_req;
  logic             acc_start;
  logic             strobe;
  logic [CNT_W-1:0] wr_cyc;
  logic [CH_W-1:0]  wr_ch;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic             rd_in_range;
  logic [IDX_W-1:0] rd_idx;
  logic [NCH-1:0]   rd_bits;
  logic [NCH-1:0]   rd_mapped;
  logic             unused_acctype;

`ifdef BUBBLE_CHSWAP_EN
  assign swap_req = ~nSWAPEN;
`else
  assign swap_req = 1'b0;
`endif

  assign unused_acctype = &{1'b0, ACCTYPE[1:0]};
  assign acc_start      = acc_idle_q & ~ACCTYPE[2];
  assign strobe         = ~nBOUTCLKEN;

  // Bank b, cycle n lives at index b*PAGE_LEN+n of each per-channel array.
  assign wr_cyc      = OUTBUFWADDR[CNT_W+CH_W-1:CH_W];
  assign wr_ch       = OUTBUFWADDR[CH_W-1:0];
  assign wr_en       = ~nOUTBUFWCLKEN & ~full_q[wb_q] & (wr_cyc < CNT_W'(PAGE_LEN));
  assign wr_idx      = wb_q ? IDX_W'(PAGE_LEN) + IDX_W'(wr_cyc) : IDX_W'(wr_cyc);
  assign rd_in_range = BOUTCYCLENUM < CNT_W'(PAGE_LEN);
  assign rd_idx      = !rd_in_range ? '0 :
                       rb_q ? IDX_W'(PAGE_LEN) + IDX_W'(BOUTCYCLENUM) : IDX_W'(BOUTCYCLENUM);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      logic mem_q [2*PAGE_LEN];

      always_ff @(posedge MCLK) begin
        if (wr_en && wr_ch == CH_W'(gi)) begin
          mem_q[wr_idx] <= OUTBUFWDATA;
        end
      end

      assign rd_bits[gi] = mem_q[rd_idx];
    end
  endgenerate

  always_comb begin
    rd_mapped = '0;
    for (int c = 0; c < NCH; c++) begin
      rd_mapped[c] = swap_q ? rd_bits[NCH-1-c] : rd_bits[c];
    end
  end

  always_comb begin
    state_d    = state_q;
    wb_d       = wb_q;
    rb_d       = rb_q;
    full_d     = full_q;
    dout_d     = dout_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    swap_d     = swap_q;

    case (state_q)
      IDLE: begin
        if (acc_start) begin
          if (full_q[rb_q]) begin
            state_d = STREAM;
            swap_d  = swap_req;
          end else begin
            state_d    = STARVE;
            underrun_d = 1'b1;
            dout_d     = '0;
          end
        end
      end
      STREAM: begin
        // An aborted access leaves the read bank full so the page is replayed.
        if (ACCTYPE[2]) begin
          state_d = IDLE;
          dout_d  = '0;
        end else if (strobe) begin
          dout_d = rd_in_range ? rd_mapped : '0;
          if (BOUTCYCLENUM == CNT_W'(PAGE_LEN - 1)) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
            state_d      = DONE;
          end
        end
      end
      STARVE: begin
        dout_d = '0;
        if (ACCTYPE[2]) state_d = IDLE;
      end
      DONE: begin
        if (ACCTYPE[2]) begin
          state_d = IDLE;
          dout_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Evaluated against the post-clear flags so a same-cycle page end frees the bank.
    if (BANKDONE) begin
      if (!full_d[wb_q]) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= IDLE;
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      full_q     <= 2'b00;
      dout_q     <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      swap_q     <= 1'b0;
      acc_idle_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      full_q     <= full_d;
      dout_q     <= dout_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
      swap_q     <= swap_d;
      acc_idle_q <= ACCTYPE[2];
    end
  end

  assign DOUT     = dout_q;
  assign WREADY   = ~full_q[wb_q];
  assign OVERRUN  = overrun_q;
  assign UNDERRUN = underrun_q;

endmodule

// File: tb/tb_bubble_out_buffer.sv
// Scoreboard bench for bubble_out_buffer (NCH=2, PAGE_LEN=584): page streaming,
// overrun/underrun flags, aborted access, same-cycle clear/BANKDONE and reset.
module tb_bubble_out_buffer;

  localparam int NCH      = 2;
  localparam int PAGE_LEN = 584;
  localparam int CNT_W    = 13;

  logic        MCLK = 1'b0;
  logic        nRESET;
  logic [2:0]  ACCTYPE;
  logic [12:0] BOUTCYCLENUM;
  logic        nBOUTCLKEN;
  logic        nOUTBUFWCLKEN;
  logic [13:0] OUTBUFWADDR;
  logic        OUTBUFWDATA;
  logic        BANKDONE;
  logic [1:0]  DOUT;
  logic        WREADY;
  logic        OVERRUN;
  logic        UNDERRUN;
`ifdef BUBBLE_CHSWAP_EN
  logic        nSWAPEN = 1'b1;
`endif

  int checks = 0;
  int errors = 0;

  logic [1:0] model [2][PAGE_LEN];
  logic [1:0] sb_q [$];
  logic [1:0] prev_exp;
  bit         have_prev;
  bit         sw = 1'b0;

  bubble_out_buffer #(.NCH(NCH), .PAGE_LEN(PAGE_LEN), .CNT_W(CNT_W)) dut (
    .MCLK          (MCLK),
    .nRESET        (nRESET),
`ifdef BUBBLE_CHSWAP_EN
    .nSWAPEN       (nSWAPEN),
`endif
    .ACCTYPE       (ACCTYPE),
    .BOUTCYCLENUM  (BOUTCYCLENUM),
    .nBOUTCLKEN    (nBOUTCLKEN),
    .nOUTBUFWCLKEN (nOUTBUFWCLKEN),
    .OUTBUFWADDR   (OUTBUFWADDR),
    .OUTBUFWDATA   (OUTBUFWDATA),
    .BANKDONE      (BANKDONE),
    .DOUT          (DOUT),
    .WREADY        (WREADY),
    .OVERRUN       (OVERRUN),
    .UNDERRUN      (UNDERRUN)
  );

  always #10 MCLK = ~MCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic pat(input int kind, input int cyc, input int ch);
    int t;
    if (kind == 0) return cyc[0] ^ ch[0];
    t = (cyc * 13 + ch * 5 + kind * 7) >> 1;
    return t[0];
  endfunction

  function automatic logic [1:0] exp_of(input int bank, input int cyc);
    logic [1:0] m;
    m = model[bank][cyc];
    return sw ? {m[0], m[1]} : m;
  endfunction

  // Writes a whole page; upd=0 models a fill that the DUT must drop.
  task automatic fill(input int kind, input int bank, input bit upd);
    for (int cyc = 0; cyc < PAGE_LEN; cyc++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        @(negedge MCLK);
        nOUTBUFWCLKEN = 1'b0;
        OUTBUFWADDR   = {13'(cyc), 1'(ch)};
        OUTBUFWDATA   = pat(kind, cyc, ch);
        if (upd) model[bank][cyc][ch] = pat(kind, cyc, ch);
      end
    end
    @(negedge MCLK);
    nOUTBUFWCLKEN = 1'b1;
    $display("fill kind=%0d bank=%0d", kind, bank);
  endtask

  task automatic bank_done();
    @(negedge MCLK);
    BANKDONE = 1'b1;
    @(negedge MCLK);
    BANKDONE = 1'b0;
    $display("bankdone wready=%0b overrun=%0b", WREADY, OVERRUN);
  endtask

  task automatic start_access();
    @(negedge MCLK);
    ACCTYPE = 3'b000;
    @(negedge MCLK);
    have_prev = 1'b0;
    $display("access start underrun=%0b", UNDERRUN);
  endtask

  task automatic end_access();
    @(negedge MCLK);
    ACCTYPE = 3'b100;
    @(negedge MCLK);
    check("idle_dout", 32'(DOUT), 32'd0);
    $display("access end dout=%0b", DOUT);
  endtask

  task automatic strobe(input int cyc, input logic [1:0] exp, input bit bd);
    logic [1:0] e;
    @(negedge MCLK);
    if (have_prev) check("hold", 32'(DOUT), 32'(prev_exp));
    nBOUTCLKEN   = 1'b0;
    BOUTCYCLENUM = 13'(cyc);
    BANKDONE     = bd;
    sb_q.push_back(exp);
    @(negedge MCLK);
    nBOUTCLKEN = 1'b1;
    BANKDONE   = 1'b0;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("dout", 32'(DOUT), 32'(e));
      prev_exp  = e;
      have_prev = 1'b1;
    end
  endtask

  task automatic stream(input int bank, input int first, input int last, input bit bd_last,
                        input bit zero);
    for (int cyc = first; cyc <= last; cyc++) begin
      strobe(cyc, zero ? 2'b00 : exp_of(bank, cyc), bd_last && (cyc == last));
    end
    $display("stream bank=%0d cycles %0d..%0d last dout=%0b", bank, first, last, DOUT);
  endtask

  initial begin
    nRESET = 1'b0; ACCTYPE = 3'b100; BOUTCYCLENUM = '0; nBOUTCLKEN = 1'b1;
    nOUTBUFWCLKEN = 1'b1; OUTBUFWADDR = '0; OUTBUFWDATA = 1'b0; BANKDONE = 1'b0;
    #35;
    check("rst_dout", 32'(DOUT), 32'd0);
    check("rst_wready", 32'(WREADY), 32'd1);
    check("rst_overrun", 32'(OVERRUN), 32'd0);
    check("rst_underrun", 32'(UNDERRUN), 32'd0);
    @(negedge MCLK);
    nRESET = 1'b1;

    // Checkerboard page, plus one out-of-range cycle strobe.
    fill(0, 0, 1'b1);
    bank_done();
    check("wready_b1_empty", 32'(WREADY), 32'd1);
    start_access();
    strobe(700, 2'b00, 1'b0);
    stream(0, 0, PAGE_LEN - 1, 1'b0, 1'b0);
    end_access();
    check("wready_after_page", 32'(WREADY), 32'd1);

    // Page-end clear and BANKDONE on the same bank in the same cycle.
    fill(1, 1, 1'b1);
    bank_done();
    fill(2, 0, 1'b1);
    bank_done();
    check("wready_both_full", 32'(WREADY), 32'd0);
    start_access();
    stream(1, 0, PAGE_LEN - 1, 1'b1, 1'b0);
    check("overrun_same_cycle", 32'(OVERRUN), 32'd0);
    check("wready_refilled", 32'(WREADY), 32'd0);
    end_access();
    start_access();
    stream(0, 0, PAGE_LEN - 1, 1'b0, 1'b0);
    end_access();
    start_access();
    stream(1, 0, PAGE_LEN - 1, 1'b0, 1'b0);
    end_access();
    check("wready_all_empty", 32'(WREADY), 32'd1);

    // Starved access.
    start_access();
    check("underrun", 32'(UNDERRUN), 32'd1);
    stream(0, 0, 19, 1'b0, 1'b1);
    strobe(PAGE_LEN - 1, 2'b00, 1'b0);
    end_access();

    // Abort at cycle 100, then replay from the same bank.
    fill(3, 0, 1'b1);
    bank_done();
    start_access();
    stream(0, 0, 100, 1'b0, 1'b0);
    end_access();
    start_access();
    stream(0, 0, PAGE_LEN - 1, 1'b0, 1'b0);
    end_access();

    // Three BANKDONE pulses with no reads.
    fill(4, 1, 1'b1);
    bank_done();
    fill(5, 0, 1'b1);
    bank_done();
    check("wready_two_full", 32'(WREADY), 32'd0);
    check("overrun_pre", 32'(OVERRUN), 32'd0);
    fill(6, 1, 1'b0);
    bank_done();
    check("overrun_third", 32'(OVERRUN), 32'd1);
    check("wready_overrun", 32'(WREADY), 32'd0);
    start_access();
    stream(1, 0, PAGE_LEN - 1, 1'b0, 1'b0);
    end_access();
    start_access();
    stream(0, 0, PAGE_LEN - 1, 1'b0, 1'b0);
    end_access();
    check("overrun_sticky", 32'(OVERRUN), 32'd1);
    check("underrun_sticky", 32'(UNDERRUN), 32'd1);

    // Reset in the middle of a page.
    fill(0, 1, 1'b1);
    bank_done();
    start_access();
    stream(1, 0, 49, 1'b0, 1'b0);
    #3;
    nRESET = 1'b0;
    #1;
    check("midrst_dout", 32'(DOUT), 32'd0);
    check("midrst_wready", 32'(WREADY), 32'd1);
    check("midrst_overrun", 32'(OVERRUN), 32'd0);
    check("midrst_underrun", 32'(UNDERRUN), 32'd0);
    ACCTYPE = 3'b100;
    sb_q.delete();
    repeat (2) @(negedge MCLK);
    nRESET = 1'b1;
    fill(1, 0, 1'b1);
    bank_done();
    start_access();
    stream(0, 0, PAGE_LEN - 1, 1'b0, 1'b0);
    end_access();

`ifdef BUBBLE_CHSWAP_EN
    fill(2, 1, 1'b1);
    bank_done();
    nSWAPEN = 1'b0;
    sw      = 1'b1;
    start_access();
    nSWAPEN = 1'b1;
    stream(1, 0, PAGE_LEN - 1, 1'b0, 1'b0);
    sw = 1'b0;
    end_access();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bubble_out_buffer.md
BUBBLE_OUT_BUFFER -- requirements
Module: bubble_out_buffer

Interface
REQ-001 Parameter NCH, 2, number of bubble data output channels; legal values are 2 and 4.
REQ-002 Parameter PAGE_LEN, 584, number of output cycles in one page.
REQ-003 Parameter CNT_W, 13, width of the cycle counter; 2^CNT_W SHALL be at least PAGE_LEN.
REQ-004 MCLK  in  1  single system clock (48 MHz); all logic SHALL be clocked on its rising edge.
REQ-005 nRESET  in  1  asynchronous, active-low reset.
REQ-006 ACCTYPE  in  3  access type from the timing generator; ACCTYPE[2]=0 means an output access is active, ACCTYPE[2]=1 means idle.
REQ-007 BOUTCYCLENUM  in  CNT_W  index of the current output cycle within the page.
REQ-008 nBOUTCLKEN  in  1  active-low output strobe, one MCLK wide.
REQ-009 nOUTBUFWCLKEN  in  1  active-low write strobe from the SPI loader.
REQ-010 OUTBUFWADDR  in  CNT_W+log2(NCH)  write bit address, laid out as {cycle, channel}.
REQ-011 OUTBUFWDATA  in  1  write data bit.
REQ-012 BANKDONE  in  1  one-cycle pulse from the loader: write bank complete.
REQ-013 DOUT  out  NCH  registered bubble data outputs.
REQ-014 WREADY  out  1  high when the write bank is empty and may be filled.
REQ-015 OVERRUN  out  1  sticky flag: BANKDONE arrived while both banks were full.
REQ-016 UNDERRUN  out  1  sticky flag: a stream started while the read bank was empty.

Function
REQ-017 Storage: two banks (ping-pong), each PAGE_LEN*NCH bits, each with a full flag; a write-bank pointer WB and a read-bank pointer RB.
REQ-018 Write: with nOUTBUFWCLKEN=0 and bank WB empty, the bit SHALL be stored at OUTBUFWADDR in bank WB; writes to a full bank SHALL be dropped; addresses at or above PAGE_LEN*NCH SHALL be dropped.
REQ-019 BANKDONE with bank WB empty: set full[WB] and toggle WB; with bank WB full: no state change and OVERRUN set to 1.
REQ-020 WREADY SHALL equal ~full[WB].
REQ-021 FSM states IDLE, STREAM, STARVE, DONE.
REQ-022 IDLE -> STREAM when ACCTYPE[2] falls to 0 and full[RB]=1; IDLE -> STARVE when ACCTYPE[2] falls to 0 and full[RB]=0; in the STARVE case UNDERRUN is set.
REQ-023 STREAM: on each nBOUTCLKEN=0, DOUT[c] SHALL take bank RB bit {BOUTCYCLENUM,c} on the next MCLK edge (1-cycle latency); at all other times DOUT SHALL hold its value.
REQ-024 STREAM: on the strobe with BOUTCYCLENUM=PAGE_LEN-1, clear full[RB], toggle RB, and go to DONE.
REQ-025 STREAM: BOUTCYCLENUM at or above PAGE_LEN SHALL output 0 on all channels.
REQ-026 STARVE: DOUT SHALL be forced to 0; the FSM stays in STARVE until ACCTYPE[2]=1, then goes to IDLE; the bank is not consumed.
REQ-027 DONE -> IDLE when ACCTYPE[2]=1; DOUT SHALL be cleared to 0 on entry to IDLE.
REQ-028 If ACCTYPE[2] returns to 1 during STREAM (aborted access): go to IDLE, DOUT=0, bank RB remains full and RB is unchanged.
REQ-029 If BANKDONE and the page-end clear hit the same bank in the same cycle: the clear SHALL be applied first, then BANKDONE is evaluated, so no OVERRUN is raised.
REQ-030 OVERRUN and UNDERRUN SHALL clear only on reset.

Reset
REQ-031 nRESET=0 SHALL immediately force: state IDLE, WB=RB=0, both full flags 0, DOUT=0, OVERRUN=0, UNDERRUN=0; WREADY therefore reads 1.
REQ-032 Bank storage contents are not reset.
REQ-033 Reset asserted mid-STREAM SHALL abandon the page; after release the block behaves as after power-up.

Configuration
REQ-034 Macro BUBBLE_CHSWAP_EN. When defined: an extra input port nSWAPEN (1 bit) exists; it is sampled on entry to STREAM; if it is 0, DOUT[c] carries stored channel NCH-1-c for the whole page.
REQ-035 Without BUBBLE_CHSWAP_EN: the port is absent and the channel mapping is always direct.

Verification (NCH=2, PAGE_LEN=584)
REQ-036 Fill bank 0 with the pattern bit={cycle[0],c}, pulse BANKDONE, stream 584 strobes -> DOUT={~cycle[0],cycle[0]} one cycle after each strobe; then WREADY=1 and RB=1.
REQ-037 Three BANKDONE pulses with no reads -> OVERRUN=1 after the third pulse, WREADY=0, and both banks still hold their data.
REQ-038 Start an access (ACCTYPE=3'b000) with both banks empty -> UNDERRUN=1 and DOUT=2'b00 throughout the access.
REQ-039 Abort the access at cycle 100, then restart -> the restarted page is read from the same bank and its cycle 0 data is correct.
REQ-040 Page-end clear and BANKDONE on the same bank in the same cycle -> OVERRUN=0 and the bank is full with the new data.
REQ-041 With BUBBLE_CHSWAP_EN defined and nSWAPEN=0 at stream start -> DOUT[0] equals stored channel 1 for all 584 cycles.
